zorgian_change_sequencer: RTL
=============================

# zorgian_change_sequencer

Sequential controller that dispenses Zorgian change one coin per cycle through a ready/valid ejector handshake while maintaining the coin inventory in registers. It sits between the vending front end, which supplies Cost/Paid and restocks, and the physical coin ejector. It replaces the fixed two-coin combinational change path with a multi-cycle greedy scheduler.

## Interface
- `MAX_COINS`, default 4: maximum coins dispensed per transaction; must be ≥1.
- `clock` in 1: single clock, all state on posedge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: accept `Cost`/`Paid`; honoured only in IDLE.
- `Cost` in 4: item cost.
- `Paid` in 4: amount inserted.
- `restock` in 1: load inventory from `restock_*`; honoured only in IDLE.
- `restock_pent`, `restock_tri`, `restock_circ` in 2 each: new counts.
- `coin_out` out 3: coin code: 101=5, 011=3, 001=1, 000=none.
- `coin_valid` out 1: `coin_out` offered to ejector.
- `coin_ready` in 1: ejector accepts.
- `busy` out 1: transaction in progress.
- `done` out 1: one-cycle completion pulse.
- `Remaining` out 4: undispensed change.
- `ExactAmount`, `CoughUpMore`, `NotEnoughChange` out 1 each: status flags.
- `pent_cnt`, `tri_cnt`, `circ_cnt` out 2 each: live inventory.

## Operation
- States: IDLE → CHECK → DISPENSE → DONE → IDLE. CHECK may go straight to DONE.
- IDLE, `restock`=1: load all three counts. Restock has priority over `start` in the same cycle, and `start` is dropped.
- IDLE, `start`=1: latch Cost/Paid and clear the coin count. Next state is CHECK.
- CHECK:
  - Paid<Cost → CoughUpMore=1, Remaining=0, go to DONE.
  - Paid==Cost → ExactAmount=(Paid!=0), Remaining=0, go to DONE.
  - Otherwise, change = Paid−Cost (4-bit, no underflow), go to DISPENSE.
- DISPENSE greedy pick, evaluated on registered change and inventory:
  - 5 if change≥5 and pent_cnt>0;
  - else 3 if change≥3 and tri_cnt>0;
  - else 1 if change≥1 and circ_cnt>0;
  - else none.
- `coin_valid` = DISPENSE ∧ pick≠none ∧ coin count<MAX_COINS. `coin_out` = pick while valid, 000 otherwise.
- Handshake (valid∧ready):
  - subtract the coin value from change;
  - decrement its inventory count;
  - increment the coin count.
- Without ready, `coin_out` and all state hold.
- DISPENSE → DONE when pick=none or coin count=MAX_COINS. This is evaluated on current registered state, with no coin offered that cycle.
- On entering DONE, register Remaining=change and NotEnoughChange=(change≠0). In DONE, `done`=1 for one cycle, then go to IDLE.
- Status outputs hold from DONE until the next accepted `start`, which clears all three flags and Remaining.
- `start`/`restock` during busy are ignored. Inventory never wraps, because a count of 0 is never picked.

## Timing
- Reset values: state IDLE; all inventory 0; `coin_out`=000; `coin_valid`, `busy`, `done`, all flags 0; Remaining 0.
- `busy`=1 in CHECK, DISPENSE, DONE.
- `start` at edge N: CHECK during N+1. Early-exit `done` during N+2. Back in IDLE at N+3.
- With ready held high: one coin per cycle from N+2. `done` comes 2 cycles after the last handshake (one DISPENSE evaluation cycle with no coin offered, then DONE).
- Reset mid-transaction: immediately IDLE with reset values. Coins already handshaken are not restored.

## Configuration
- `ZCB_GREEDY_ONLY_EN`:
  - defined: pick strictly greedy as above;
  - undefined: lookahead. When change∈{6,7} and pent_cnt>0 but circ_cnt<change−5, pick 3 instead of 5 if tri_cnt≥2. This avoids stranding change.

## Structure
- Package `zcb_pkg` holds:
  - `coin_t` enum (COIN_NONE=3'b000, COIN_CIRCLE=3'b001, COIN_TRI=3'b011, COIN_PENT=3'b101);
  - `zcb_state_t` enum;
  - coin value constants.
- Sub-module `zcb_coin_select`: combinational pick from change plus counts. The Configuration macro is applied here only.

## Test plan
- Reset, restock 3/3/3, Cost=2 Paid=10, ready=1 → coins 101, 011; Remaining=0; NE=0; inventory 2/2/3.
- Restock 1/2/3, Cost=1 Paid=11, MAX_COINS=2 → coins 101, 011; Remaining=2; NotEnoughChange=1.
- Cost=10 Paid=4 → CoughUpMore=1, no coin_valid, done at N+2. Cost=Paid=0 → ExactAmount=0.
- Change=5, coin_ready low 3 cycles → coin_out=101 stable; pent_cnt decrements only on the accepting cycle.
- `start`+`restock` same IDLE cycle → restock applied, busy stays 0. `start` during DISPENSE → ignored.
- Reset asserted mid-DISPENSE → all outputs at reset values on the next sample; inventory 0.

Source files
------------

// File: rtl/zcb_pkg.sv
// Shared types and constants for the Zorgian change sequencer.
package zcb_pkg;

  typedef enum logic [2:0] {
    COIN_NONE   = 3'b000,
    COIN_CIRCLE = 3'b001,
    COIN_TRI    = 3'b011,
    COIN_PENT   = 3'b101
  } coin_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_DISPENSE,
    ST_DONE
  } zcb_state_t;

  localparam logic [3:0] VAL_PENT = 4'd5;
  localparam logic [3:0] VAL_TRI  = 4'd3;
  localparam logic [3:0] VAL_CIRC = 4'd1;

  function automatic logic [3:0] coin_value(input coin_t c);
    case (c)
      COIN_PENT:   coin_value = VAL_PENT;
      COIN_TRI:    coin_value = VAL_TRI;
      COIN_CIRCLE: coin_value = VAL_CIRC;
      default:     coin_value = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/zcb_coin_select.sv
// Combinational coin pick from remaining change and inventory.
// ZCB_GREEDY_ONLY_EN defined: strict greedy; undefined: 6/7 lookahead.
module zcb_coin_select
  import zcb_pkg::*;
(
  input  logic [3:0] change,
  input  logic [1:0] pent_cnt,
  input  logic [1:0] tri_cnt,
  input  logic [1:0] circ_cnt,
  output coin_t      pick
);

`ifdef ZCB_GREEDY_ONLY_EN
  localparam bit LOOKAHEAD = 1'b0;
`else
  localparam bit LOOKAHEAD = 1'b1;
`endif

  always_comb begin
    pick = COIN_NONE;
    if (change >= VAL_PENT && pent_cnt != 2'd0)
      pick = COIN_PENT;
    else if (change >= VAL_TRI && tri_cnt != 2'd0)
      pick = COIN_TRI;
    else if (change >= VAL_CIRC && circ_cnt != 2'd0)
      pick = COIN_CIRCLE;
    // A pent on 6/7 would strand change when circles can't cover the rest
    if (LOOKAHEAD && pick == COIN_PENT && (change == 4'd6 || change == 4'd7) &&
        {2'b00, circ_cnt} < (change - VAL_PENT) && tri_cnt >= 2'd2)
      pick = COIN_TRI;
  end

endmodule

// File: rtl/zorgian_change_sequencer.sv
// Multi-cycle change dispenser: one coin per ready/valid handshake, with inventory.
// Pick policy selected by ZCB_GREEDY_ONLY_EN inside zcb_coin_select.
module zorgian_change_sequencer
  import zcb_pkg::*;
#(
  parameter int unsigned MAX_COINS = 4
)
(
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] Cost,
  input  logic [3:0] Paid,
  input  logic       restock,
  input  logic [1:0] restock_pent,
  input  logic [1:0] restock_tri,
  input  logic [1:0] restock_circ,
  output logic [2:0] coin_out,
  output logic       coin_valid,
  input  logic       coin_ready,
  output logic       busy,
  output logic       done,
  output logic [3:0] Remaining,
  output logic       ExactAmount,
  output logic       CoughUpMore,
  output logic       NotEnoughChange,
  output logic [1:0] pent_cnt,
  output logic [1:0] tri_cnt,
  output logic [1:0] circ_cnt
);

  localparam int unsigned CW = $clog2(MAX_COINS + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_COINS);

  zcb_state_t    state, next_state;
  logic [3:0]    cost_q, paid_q, change_q, remaining_q;
  logic [CW-1:0] count_q;
  logic [1:0]    pent_q, tri_q, circ_q;
  logic          exact_q, cough_q, ne_q;
  logic          handshake;
  coin_t         pick;

  zcb_coin_select u_sel (
    .change   (change_q),
    .pent_cnt (pent_q),
    .tri_cnt  (tri_q),
    .circ_cnt (circ_q),
    .pick     (pick)
  );

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    coin_valid = 1'b0;
    coin_out   = COIN_NONE;
    handshake  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!restock && start) next_state = ST_CHECK;
      end
      ST_CHECK: begin
        busy       = 1'b1;
        next_state = (paid_q > cost_q) ? ST_DISPENSE : ST_DONE;
      end
      ST_DISPENSE: begin
        busy = 1'b1;
        if (pick != COIN_NONE && count_q < MAX_C) begin
          coin_valid = 1'b1;
          coin_out   = pick;
          handshake  = coin_ready;
        end else begin
          next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cost_q      <= '0;
      paid_q      <= '0;
      change_q    <= '0;
      remaining_q <= '0;
      count_q     <= '0;
      pent_q      <= '0;
      tri_q       <= '0;
      circ_q      <= '0;
      exact_q     <= 1'b0;
      cough_q     <= 1'b0;
      ne_q        <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        ST_IDLE: begin
          if (restock) begin
            pent_q <= restock_pent;
            tri_q  <= restock_tri;
            circ_q <= restock_circ;
          end else if (start) begin
            cost_q      <= Cost;
            paid_q      <= Paid;
            count_q     <= '0;
            remaining_q <= '0;
            exact_q     <= 1'b0;
            cough_q     <= 1'b0;
            ne_q        <= 1'b0;
          end
        end
        ST_CHECK: begin
          if (paid_q < cost_q)
            cough_q <= 1'b1;
          else if (paid_q == cost_q)
            exact_q <= (paid_q != 4'd0);
          else
            change_q <= paid_q - cost_q;
        end
        ST_DISPENSE: begin
          if (handshake) begin
            change_q <= change_q - coin_value(pick);
            count_q  <= count_q + CW'(1);
            case (pick)
              COIN_PENT:   pent_q <= pent_q - 2'd1;
              COIN_TRI:    tri_q  <= tri_q - 2'd1;
              COIN_CIRCLE: circ_q <= circ_q - 2'd1;
              default:     ;
            endcase
          end else if (next_state == ST_DONE) begin
            remaining_q <= change_q;
            ne_q        <= (change_q != 4'd0);
          end
        end
        default: ;
      endcase
    end
  end

  assign Remaining       = remaining_q;
  assign ExactAmount     = exact_q;
  assign CoughUpMore     = cough_q;
  assign NotEnoughChange = ne_q;
  assign pent_cnt        = pent_q;
  assign tri_cnt         = tri_q;
  assign circ_cnt        = circ_q;

endmodule
